// File: rtl/pipeline5_regbank.sv
// pipeline5_regbank: writeback-side register bank for pipeline5.
// Two registered read ports, one write port, write-commit counter.
//
// Ports:
//   clk_in     - clock, all state updates on the rising edge
//   RST        - asynchronous active-low reset
//   wb_en      - write enable (pipeline5.en_out)
//   wb_addr    - write address (pipeline5.addr_out)
//   wb_data    - signed write data (pipeline5.data_out)
//   rd_addr_a  - read port A address, sampled each rising edge
//   rd_addr_b  - read port B address, sampled each rising edge
//   rd_data_a  - registered read data, port A
//   rd_data_b  - registered read data, port B
//   wr_count   - committed writes since reset, wraps silently
//
// Build option:
//   PIPELINE5_REGBANK_BYPASS_EN - when defined, a read that collides
//   with a committing write returns the new data (write-first).
//   When undefined the read returns the old contents (read-first).
module pipeline5_regbank #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk_in,
    input  logic                             RST,
    input  logic                             wb_en,
    input  logic        [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic signed [DATA_WIDTH-1:0]     wb_data,
    input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_b,
    output logic signed [DATA_WIDTH-1:0]     rd_data_a,
    output logic signed [DATA_WIDTH-1:0]     rd_data_b,
    output logic        [CNT_WIDTH-1:0]      wr_count
);

    localparam int DEPTH = 1 << REG_ADDR_WIDTH;

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic signed [DATA_WIDTH-1:0] rd_data_a_q;
    logic signed [DATA_WIDTH-1:0] rd_data_a_d;
    logic signed [DATA_WIDTH-1:0] rd_data_b_q;
    logic signed [DATA_WIDTH-1:0] rd_data_b_d;

    logic [CNT_WIDTH-1:0] wr_count_q;
    logic [CNT_WIDTH-1:0] wr_count_d;

    logic wr_commit;

    // Register 0 is hardwired zero: writes to it neither land nor count.
    assign wr_commit = wb_en && (wb_addr != '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_commit) begin
            mem_d[wb_addr] = wb_data;
        end
    end

    // Entry 0 of mem_q is never written, but the read path still
    // masks address 0 so the zero register does not rely on storage.
    always_comb begin
        rd_data_a_d = '0;
        if (rd_addr_a != '0) begin
            rd_data_a_d = mem_q[rd_addr_a];
        end
`ifdef PIPELINE5_REGBANK_BYPASS_EN
        if (wr_commit && (rd_addr_a == wb_addr)) begin
            rd_data_a_d = wb_data;
        end
`endif
    end

    always_comb begin
        rd_data_b_d = '0;
        if (rd_addr_b != '0) begin
            rd_data_b_d = mem_q[rd_addr_b];
        end
`ifdef PIPELINE5_REGBANK_BYPASS_EN
        if (wr_commit && (rd_addr_b == wb_addr)) begin
            rd_data_b_d = wb_data;
        end
`endif
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit) begin
            wr_count_d = wr_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            wr_count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign wr_count  = wr_count_q;

endmodule
